// File: rtl/sap_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : sap_controller_if
// Description : Bus and control-strobe bundle between the SAP-U controller
//               (master) and the datapath / test environment (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface sap_controller_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);

  logic                  step_en;
  logic [DATA_WIDTH-1:0] bus_in;
  logic [DATA_WIDTH-1:0] bus_out;
  logic                  reg_a_load_n;
  logic                  reg_a_bus_enable_n;
  logic                  reg_b_load_n;
  logic                  alu_enable;
  logic                  alu_subtract;
  logic                  ram_output_enable;
  logic                  ram_control_signal;
  logic                  ram_load_mar_reg;
  logic                  out_load;
  logic                  halted;
  logic [ADDR_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] ir;
  logic [2:0]            step;

  // Controller side: consumes the enable and the bus, drives everything else.
  modport master (
    input  step_en, bus_in,
    output bus_out, reg_a_load_n, reg_a_bus_enable_n, reg_b_load_n,
           alu_enable, alu_subtract, ram_output_enable, ram_control_signal,
           ram_load_mar_reg, out_load, halted, pc, ir, step
  );

  // Datapath side: mirror image of the controller view.
  modport slave (
    output step_en, bus_in,
    input  bus_out, reg_a_load_n, reg_a_bus_enable_n, reg_b_load_n,
           alu_enable, alu_subtract, ram_output_enable, ram_control_signal,
           ram_load_mar_reg, out_load, halted, pc, ir, step
  );

endinterface
`default_nettype wire

// File: rtl/sap_controller.sv
`default_nettype none
// ============================================================================
// Module      : sap_controller
// Description : SAP-U control sequencer. Holds PC, IR and the T-state
//               counter and decodes (step, opcode, halted) into the control
//               strobes and the controller's share of the OR-combined bus.
// Revision    : 1.0 - initial release
// ============================================================================
module sap_controller #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  sap_controller_if.master ctrl
);

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } step_t;

  step_t                 step_q, step_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] ir_q, ir_d;
  logic                  halted_q, halted_d;

  // Internal strobes are active-high; polarity and reset gating are applied
  // once at the outputs.
  logic                  a_load, a_bus, b_load, alu_en, alu_sub;
  logic                  ram_oe, ram_we, mar_load, out_ld;
  logic [DATA_WIDTH-1:0] bus_val;

  logic                  advance;
  logic [3:0]            opcode;
  logic [3:0]            fetched_op;
  logic [DATA_WIDTH-1:0] pc_ext;
  logic [DATA_WIDTH-1:0] operand_ext;

  assign advance     = ctrl.step_en & ~halted_q;
  assign opcode      = ir_q[DATA_WIDTH-1 -: 4];
  assign fetched_op  = ctrl.bus_in[DATA_WIDTH-1 -: 4];
  assign pc_ext      = {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, pc_q};
  assign operand_ext = {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, ir_q[ADDR_WIDTH-1:0]};

  // Opcodes that continue past the fetch steps into T2.
  function automatic logic has_execute(input logic [3:0] op);
    case (op)
      OP_LDA, OP_ADD, OP_SUB, OP_STA,
      OP_LDI, OP_JMP, OP_OUT, OP_HLT: has_execute = 1'b1;
      default:                        has_execute = 1'b0;
    endcase
  endfunction

  // State register: everything freezes unless enabled and not halted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      step_q   <= T0;
      pc_q     <= '0;
      ir_q     <= '0;
      halted_q <= 1'b0;
    end else if (advance) begin
      step_q   <= step_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      halted_q <= halted_d;
    end
  end

  // Next-state and strobe decode from the registered step/opcode/halted.
  always_comb begin
    step_d   = step_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    halted_d = halted_q;
    a_load   = 1'b0;
    a_bus    = 1'b0;
    b_load   = 1'b0;
    alu_en   = 1'b0;
    alu_sub  = 1'b0;
    ram_oe   = 1'b0;
    ram_we   = 1'b0;
    mar_load = 1'b0;
    out_ld   = 1'b0;
    bus_val  = '0;

    if (!halted_q) begin
      case (step_q)
        T0: begin
          bus_val  = pc_ext;
          mar_load = 1'b1;
          step_d   = T1;
        end
        T1: begin
          // The step after fetch depends on the opcode being loaded now,
          // not on the stale IR contents.
          ram_oe = 1'b1;
          ir_d   = ctrl.bus_in;
          pc_d   = pc_q + ADDR_WIDTH'(1);
          step_d = has_execute(fetched_op) ? T2 : T0;
        end
        T2: begin
          step_d = T0;
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              bus_val  = operand_ext;
              mar_load = 1'b1;
              step_d   = T3;
            end
            OP_LDI: begin
              bus_val = operand_ext;
              a_load  = 1'b1;
            end
            OP_JMP: begin
              bus_val = operand_ext;
              pc_d    = ir_q[ADDR_WIDTH-1:0];
            end
            OP_OUT: begin
              a_bus  = 1'b1;
              out_ld = 1'b1;
            end
            OP_HLT: begin
              halted_d = 1'b1;
            end
            default: ;
          endcase
        end
        T3: begin
          step_d = T0;
          case (opcode)
            OP_LDA: begin
              ram_oe = 1'b1;
              a_load = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              ram_oe = 1'b1;
              b_load = 1'b1;
              step_d = T4;
            end
            OP_STA: begin
              a_bus  = 1'b1;
              ram_we = 1'b1;
            end
            default: ;
          endcase
        end
        T4: begin
          step_d = T0;
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            alu_en  = 1'b1;
            a_load  = 1'b1;
            alu_sub = (opcode == OP_SUB);
          end
        end
        default: step_d = T0;
      endcase
    end
  end

  // Outputs are forced inactive for as long as reset is asserted.
  assign ctrl.bus_out            = reset_n ? bus_val : '0;
  assign ctrl.reg_a_load_n       = ~(reset_n & a_load);
  assign ctrl.reg_a_bus_enable_n = ~(reset_n & a_bus);
  assign ctrl.reg_b_load_n       = ~(reset_n & b_load);
  assign ctrl.alu_enable         = reset_n & alu_en;
  assign ctrl.alu_subtract       = reset_n & alu_sub;
  assign ctrl.ram_output_enable  = reset_n & ram_oe;
  assign ctrl.ram_control_signal = reset_n & ram_we;
  assign ctrl.ram_load_mar_reg   = reset_n & mar_load;
  assign ctrl.out_load           = reset_n & out_ld;
  assign ctrl.halted             = halted_q;
  assign ctrl.pc                 = pc_q;
  assign ctrl.ir                 = ir_q;
  assign ctrl.step               = step_q;

endmodule
`default_nettype wire

// File: tb/tb_sap_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_sap_controller
// Description : Scoreboard bench for sap_controller. An instruction-level
//               model expands each fetched instruction into its expected
//               per-step observations; a monitor compares every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sap_controller;

  typedef struct packed {
    logic [2:0] step;
    logic       halted;
    logic [3:0] pc;
    logic [7:0] ir;
    logic [7:0] bus;
    logic [8:0] ctl;  // a_ld_n a_bus_n b_ld_n alu sub ram_oe ram_we mar out
  } obs_t;

  localparam logic [8:0] IDLE = 9'b111_000000;

  logic clk;
  logic reset_n;

  sap_controller_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) sif ();

  sap_controller #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ctrl    (sif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  obs_t       exp_q[$];
  obs_t       plan_q[$];
  logic [7:0] feed_q[$];
  logic [7:0] mem [16];

  logic [3:0] m_pc;
  logic [7:0] m_ir;
  bit         m_halt;
  bit         reset_on_add;
  bit         stall_req;
  int         stall_cnt;
  bit         rand_en;
  bit         count_en;
  int         req_cnt;
  int         ack_cnt;
  int         out_pulses;
  int         asserts;
  int         fails;

  function automatic logic [8:0] cw(bit a_ld, bit a_bus, bit b_ld, bit alu,
                                    bit sub, bit oe, bit we, bit mar, bit outl);
    return {~a_ld, ~a_bus, ~b_ld, alu, sub, oe, we, mar, outl};
  endfunction

  function automatic obs_t mk(logic [2:0] s, logic [3:0] p, logic [7:0] i,
                              logic [7:0] b, logic [8:0] c);
    obs_t o;
    o.step = s; o.halted = 1'b0; o.pc = p; o.ir = i; o.bus = b; o.ctl = c;
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.step   = sif.step;
    o.halted = sif.halted;
    o.pc     = sif.pc;
    o.ir     = sif.ir;
    o.bus    = sif.bus_out;
    o.ctl    = {sif.reg_a_load_n, sif.reg_a_bus_enable_n, sif.reg_b_load_n,
                sif.alu_enable, sif.alu_subtract, sif.ram_output_enable,
                sif.ram_control_signal, sif.ram_load_mar_reg, sif.out_load};
    return o;
  endfunction

  // Instruction-level model: one fetched instruction becomes its list of
  // expected step observations, and the architectural PC/IR move on.
  task automatic expand();
    logic [7:0] ins;
    logic [3:0] op;
    logic [7:0] opnd;
    ins  = mem[m_pc];
    op   = ins[7:4];
    opnd = {4'h0, ins[3:0]};
    plan_q.push_back(mk(3'd0, m_pc, m_ir, {4'h0, m_pc}, cw(0,0,0,0,0,0,0,1,0)));
    feed_q.push_back(ins);
    plan_q.push_back(mk(3'd1, m_pc, m_ir, 8'h00, cw(0,0,0,0,0,1,0,0,0)));
    feed_q.push_back(ins);
    m_pc = m_pc + 4'd1;
    m_ir = ins;
    case (op)
      4'h1: begin
        plan_q.push_back(mk(3'd2, m_pc, m_ir, opnd, cw(0,0,0,0,0,0,0,1,0)));
        plan_q.push_back(mk(3'd3, m_pc, m_ir, 8'h00, cw(1,0,0,0,0,1,0,0,0)));
      end
      4'h2, 4'h3: begin
        plan_q.push_back(mk(3'd2, m_pc, m_ir, opnd, cw(0,0,0,0,0,0,0,1,0)));
        plan_q.push_back(mk(3'd3, m_pc, m_ir, 8'h00, cw(0,0,1,0,0,1,0,0,0)));
        plan_q.push_back(mk(3'd4, m_pc, m_ir, 8'h00, cw(1,0,0,1,op == 4'h3,0,0,0,0)));
      end
      4'h4: begin
        plan_q.push_back(mk(3'd2, m_pc, m_ir, opnd, cw(0,0,0,0,0,0,0,1,0)));
        plan_q.push_back(mk(3'd3, m_pc, m_ir, 8'h00, cw(0,1,0,0,0,0,1,0,0)));
      end
      4'h5: plan_q.push_back(mk(3'd2, m_pc, m_ir, opnd, cw(1,0,0,0,0,0,0,0,0)));
      4'h6: begin
        plan_q.push_back(mk(3'd2, m_pc, m_ir, opnd, IDLE));
        m_pc = ins[3:0];
      end
      4'hE: plan_q.push_back(mk(3'd2, m_pc, m_ir, 8'h00, cw(0,1,0,0,0,0,0,0,1)));
      4'hF: begin
        plan_q.push_back(mk(3'd2, m_pc, m_ir, 8'h00, IDLE));
        m_halt = 1'b1;
      end
      default: ;
    endcase
    while (feed_q.size() < plan_q.size()) feed_q.push_back(8'h00);
  endtask

  // Asserts reset mid-cycle for one clock; expects everything inactive.
  task automatic apply_reset();
    sif.step_en = 1'($urandom);
    sif.bus_in  = 8'($urandom);
    reset_n     = 1'b0;
    exp_q.push_back(mk(3'd0, 4'h0, 8'h00, 8'h00, IDLE));
    @(posedge clk); #1;
    reset_n = 1'b1;
    plan_q.delete();
    feed_q.delete();
    m_pc   = 4'h0;
    m_ir   = 8'h00;
    m_halt = 1'b0;
  endtask

  // One clock of stimulus, entered and left 1 time unit after a rising edge.
  task automatic cycle();
    obs_t       cur;
    logic [7:0] feed;
    bit         en;
    if (plan_q.size() == 0 && !m_halt) expand();
    if (plan_q.size() == 0) begin
      cur        = mk(3'd0, m_pc, m_ir, 8'h00, IDLE);
      cur.halted = 1'b1;
      feed       = 8'($urandom);
    end else begin
      cur  = plan_q[0];
      feed = feed_q[0];
    end
    if (reset_on_add && cur.step == 3'd3 && cur.ir[7:4] == 4'h2) begin
      reset_on_add = 1'b0;
      apply_reset();
      return;
    end
    if (stall_req && cur.step == 3'd1 && !cur.halted) begin
      stall_cnt = 5;
      stall_req = 1'b0;
    end
    if (stall_cnt > 0) begin
      en = 1'b0;
      stall_cnt--;
    end else begin
      en = rand_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    sif.step_en = en;
    sif.bus_in  = (en && cur.step == 3'd1 && !cur.halted) ? feed : 8'($urandom);
    exp_q.push_back(cur);
    @(posedge clk); #1;
    if (en && plan_q.size() > 0) begin
      plan_q.delete(0);
      feed_q.delete(0);
    end
  endtask

  // Monitor: compares every presented cycle against the scoreboard queue.
  initial begin
    obs_t e;
    obs_t a;
    int   srcs;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = sample();
        asserts++;
        if (a !== e) begin
          fails++;
          $display("FAIL state t=%0t actual step=%0d halted=%0b pc=%h ir=%h bus=%h ctl=%b required step=%0d halted=%0b pc=%h ir=%h bus=%h ctl=%b",
                   $time, a.step, a.halted, a.pc, a.ir, a.bus, a.ctl,
                   e.step, e.halted, e.pc, e.ir, e.bus, e.ctl);
        end
        srcs = int'(sif.alu_enable) + int'(sif.ram_output_enable) +
               int'(!sif.reg_a_bus_enable_n);
        asserts++;
        if (srcs > 1 || (srcs == 1 && sif.bus_out != 8'h00)) begin
          fails++;
          $display("FAIL bus_exclusive t=%0t actual sources=%0d bus_out=%h required at most one source",
                   $time, srcs, sif.bus_out);
        end
      end
      if (count_en && sif.out_load && sif.step_en) out_pulses++;
      if (req_cnt != ack_cnt) begin
        ack_cnt = req_cnt;
        asserts++;
        if (out_pulses != 1) begin
          fails++;
          $display("FAIL out_load_pulses actual=%0d required=1", out_pulses);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n      = 1'b0;
    sif.step_en  = 1'b0;
    sif.bus_in   = 8'h00;
    m_pc         = 4'h0;
    m_ir         = 8'h00;
    m_halt       = 1'b0;
    reset_on_add = 1'b0;
    stall_req    = 1'b0;
    stall_cnt    = 0;
    rand_en      = 1'b0;
    count_en     = 1'b0;
    req_cnt      = 0;
    repeat (2) @(posedge clk);
    #1;

    // LDA 14 / ADD 15 / OUT / HLT with a stall at the first T1 and a reset
    // during the first ADD's T3.
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mem[0] = 8'h1E; mem[1] = 8'h2F; mem[2] = 8'hE0; mem[3] = 8'hF0;
    apply_reset();
    reset_on_add = 1'b1;
    stall_req    = 1'b1;
    count_en     = 1'b1;
    repeat (60) cycle();
    count_en = 1'b0;
    req_cnt++;

    // JMP from pc 15 (wrap), undefined opcode, SUB, STA, LDI, HLT.
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mem[0]  = 8'h6F; mem[15] = 8'h6A;
    mem[10] = 8'h70; mem[11] = 8'h3F; mem[12] = 8'h4C;
    mem[13] = 8'h5A; mem[14] = 8'hF0;
    apply_reset();
    rand_en = 1'b1;
    repeat (80) cycle();

    // Random programs with random step_en.
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
      apply_reset();
      repeat (150) cycle();
    end

    sif.step_en = 1'b0;
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
`default_nettype wire
